decode_stage: RTL and testbench

Registered, handshaked instruction-decode pipeline stage for the 9-bit core ISA, generalised in register and immediate widths. It replaces the purely combinational field split between fetch and register-read with a valid/ready stage that has a two-entry skid buffer, format classification, configurable immediate extension and illegal-opcode detection. It sits between the fetch unit (upstream) and the register file / execute stage (downstream).

---
 rtl/decode_pkg.sv | 59 +++++
 rtl/decode_logic.sv | 54 +++++
 rtl/decode_stage.sv | 162 ++++++++++++++++
 tb/tb_decode_stage.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared types for the decode stage: format codes, skid-buffer states and the
// format selector patterns applied to the top five instruction bits.
package decode_pkg;

  typedef enum logic [2:0] {
    FMT_R3  = 3'd0,
    FMT_R2  = 3'd1,
    FMT_R1  = 3'd2,
    FMT_BR  = 3'd3,
    FMT_JMP = 3'd4,
    FMT_IMM = 3'd5,
    FMT_ILL = 3'd6
  } fmt_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } skid_st_e;

  localparam int DEF_INSTR_W = 9;
  localparam int DEF_REG_W   = 4;
  localparam int DEF_IMM_W   = 8;
  localparam int SEL_W       = 5;

  localparam logic [SEL_W-1:0] SEL_R3  = 5'b00???;
  localparam logic [SEL_W-1:0] SEL_BR  = 5'b0111?;
  localparam logic [SEL_W-1:0] SEL_JMP = 5'b10000;
  localparam logic [SEL_W-1:0] SEL_R2  = 5'b01???;
  localparam logic [SEL_W-1:0] SEL_R1  = 5'b100??;
  localparam logic [SEL_W-1:0] SEL_IMM = 5'b101??;

  // Reference record layout at the default widths.
  typedef struct packed {
    logic [DEF_INSTR_W-1:0] opcode;
    fmt_e                   fmt;
    logic [DEF_REG_W-1:0]   reg0;
    logic [DEF_REG_W-1:0]   reg1;
    logic [DEF_IMM_W-1:0]   imm;
    logic                   illegal;
  } dec_rec_t;

  // Item order encodes decode priority: BR and JMP must be tested before the
  // wider R2/R1 patterns that overlap them.
  function automatic fmt_e classify(input logic [SEL_W-1:0] t);
    fmt_e f;
    casez (t)
      SEL_R3:  f = FMT_R3;
      SEL_BR:  f = FMT_BR;
      SEL_JMP: f = FMT_JMP;
      SEL_R2:  f = FMT_R2;
      SEL_R1:  f = FMT_R1;
      SEL_IMM: f = FMT_IMM;
      default: f = FMT_ILL;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/decode_logic.sv
// Combinational instruction-to-record field split; unused fields are driven to 0.
module decode_logic
  import decode_pkg::*;
#(
  parameter int INSTR_W = 9,
  parameter int REG_W   = 4,
  parameter int IMM_W   = 8,
  parameter int BR_SEXT = 1
) (
  input  logic [INSTR_W-1:0] instr_i,
  output logic [INSTR_W-1:0] opcode_o,
  output fmt_e               fmt_o,
  output logic [REG_W-1:0]   reg0_o,
  output logic [REG_W-1:0]   reg1_o,
  output logic [IMM_W-1:0]   imm_o,
  output logic               illegal_o
);

  fmt_e fmt_s;

  assign fmt_s    = classify(instr_i[INSTR_W-1 -: SEL_W]);
  assign opcode_o = instr_i;
  assign fmt_o    = fmt_s;

  // Field extraction per format.
  always_comb begin
    reg0_o    = '0;
    reg1_o    = '0;
    imm_o     = '0;
    illegal_o = 1'b0;
    case (fmt_s)
      FMT_R3: begin
        reg0_o = REG_W'(instr_i[5:3]);
        reg1_o = REG_W'(instr_i[2:0]);
      end
      FMT_R2: begin
        reg0_o = REG_W'(instr_i[3:2]);
        reg1_o = REG_W'(instr_i[1:0]);
      end
      FMT_R1: reg1_o = REG_W'(instr_i[3:2]);
      FMT_BR: begin
        if (BR_SEXT != 0) begin
          imm_o = IMM_W'($signed(instr_i[3:0]));
        end else begin
          imm_o = IMM_W'(instr_i[3:0]);
        end
      end
      FMT_JMP, FMT_IMM: imm_o = IMM_W'(instr_i[3:0]);
      FMT_ILL: illegal_o = 1'b1;
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// Handshaked decode stage with a two-entry skid buffer (main + skid registers).
// Optional illegal-opcode trap is enabled by defining DECODE_TRAP_EN.
module decode_stage
  import decode_pkg::*;
#(
  parameter int INSTR_W = 9,
  parameter int REG_W   = 4,
  parameter int IMM_W   = 8,
  parameter int BR_SEXT = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_opcode,
  output fmt_e               out_fmt,
  output logic [REG_W-1:0]   out_reg0,
  output logic [REG_W-1:0]   out_reg1,
  output logic [IMM_W-1:0]   out_imm,
  output logic               out_illegal,
  input  logic               trap_clr,
  output logic               trap
);

  typedef struct packed {
    logic [INSTR_W-1:0] opcode;
    fmt_e               fmt;
    logic [REG_W-1:0]   reg0;
    logic [REG_W-1:0]   reg1;
    logic [IMM_W-1:0]   imm;
    logic               illegal;
  } rec_t;

  logic [INSTR_W-1:0] dec_opcode_s;
  fmt_e               dec_fmt_s;
  logic [REG_W-1:0]   dec_reg0_s;
  logic [REG_W-1:0]   dec_reg1_s;
  logic [IMM_W-1:0]   dec_imm_s;
  logic               dec_illegal_s;

  rec_t     dec_s, main_q, main_d, skid_q, skid_d;
  skid_st_e state_q, state_d;
  logic     trap_q, trap_d;
  logic     in_xfer_s, out_xfer_s, in_ready_s, out_valid_s;

  decode_logic #(
    .INSTR_W(INSTR_W), .REG_W(REG_W), .IMM_W(IMM_W), .BR_SEXT(BR_SEXT)
  ) u_decode (
    .instr_i  (in_instr),
    .opcode_o (dec_opcode_s),
    .fmt_o    (dec_fmt_s),
    .reg0_o   (dec_reg0_s),
    .reg1_o   (dec_reg1_s),
    .imm_o    (dec_imm_s),
    .illegal_o(dec_illegal_s)
  );

  assign dec_s      = '{dec_opcode_s, dec_fmt_s, dec_reg0_s, dec_reg1_s, dec_imm_s, dec_illegal_s};
  assign in_xfer_s  = in_valid && in_ready_s;
  assign out_xfer_s = out_valid_s && out_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and data-path steering for the main and skid entries.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (in_xfer_s) begin
          state_d = ST_ONE;
          main_d  = dec_s;
        end else begin
          state_d = ST_EMPTY;
        end
      end
      ST_ONE: begin
        if (in_xfer_s && out_xfer_s) begin
          main_d = dec_s;
        end else if (in_xfer_s) begin
          state_d = ST_TWO;
          skid_d  = dec_s;
        end else if (out_xfer_s) begin
          state_d = ST_EMPTY;
        end else begin
          state_d = ST_ONE;
        end
      end
      ST_TWO: begin
        if (out_xfer_s) begin
          state_d = ST_ONE;
          main_d  = skid_q;
        end else begin
          state_d = ST_TWO;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // Outputs depend only on registered state, never on out_ready.
  always_comb begin
    in_ready_s  = (state_q != ST_TWO) && !trap_q;
    out_valid_s = (state_q != ST_EMPTY);
  end

  // Record and trap registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= '0;
      skid_q <= '0;
      trap_q <= 1'b0;
    end else begin
      main_q <= main_d;
      skid_q <= skid_d;
      trap_q <= trap_d;
    end
  end

`ifdef DECODE_TRAP_EN
  // Clear wins over a new illegal acceptance in the same cycle.
  always_comb begin
    if (trap_clr) begin
      trap_d = 1'b0;
    end else if (in_xfer_s && dec_s.illegal) begin
      trap_d = 1'b1;
    end else begin
      trap_d = trap_q;
    end
  end
`else
  logic unused_trap_clr_s;
  assign unused_trap_clr_s = trap_clr;

  // Trap disabled: illegal records just flow through.
  always_comb begin
    trap_d = 1'b0;
  end
`endif

  assign in_ready    = in_ready_s;
  assign out_valid   = out_valid_s;
  assign out_opcode  = main_q.opcode;
  assign out_fmt     = main_q.fmt;
  assign out_reg0    = main_q.reg0;
  assign out_reg1    = main_q.reg1;
  assign out_imm     = main_q.imm;
  assign out_illegal = main_q.illegal;
  assign trap        = trap_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: vector table plus backpressure, trap and
// reset-in-TWO sequences. A second instance checks BR zero-extension.
module tb_decode_stage;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready, in_ready_z;
  logic [8:0] in_instr;
  logic       out_valid, out_valid_z;
  logic       out_ready;
  logic [8:0] out_opcode, out_opcode_z;
  logic [2:0] out_fmt, out_fmt_z;
  logic [3:0] out_reg0, out_reg0_z, out_reg1, out_reg1_z;
  logic [7:0] out_imm, out_imm_z;
  logic       out_illegal, out_illegal_z;
  logic       trap_clr;
  logic       trap, trap_z;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  decode_stage #(.INSTR_W(9), .REG_W(4), .IMM_W(8), .BR_SEXT(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_fmt(out_fmt), .out_reg0(out_reg0),
    .out_reg1(out_reg1), .out_imm(out_imm), .out_illegal(out_illegal),
    .trap_clr(trap_clr), .trap(trap)
  );

  decode_stage #(.INSTR_W(9), .REG_W(4), .IMM_W(8), .BR_SEXT(0)) u_dut_z (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_z),
    .in_instr(in_instr), .out_valid(out_valid_z), .out_ready(out_ready),
    .out_opcode(out_opcode_z), .out_fmt(out_fmt_z), .out_reg0(out_reg0_z),
    .out_reg1(out_reg1_z), .out_imm(out_imm_z), .out_illegal(out_illegal_z),
    .trap_clr(trap_clr), .trap(trap_z)
  );

  typedef struct {
    logic [8:0] instr;
    logic [2:0] fmt;
    logic [3:0] r0;
    logic [3:0] r1;
    logic [7:0] imm_s;
    logic [7:0] imm_z;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_rec(input string nm, input vec_t v);
    chk({nm, ".valid"}, 32'(out_valid), 32'd1);
    chk({nm, ".opcode"}, 32'(out_opcode), 32'(v.instr));
    chk({nm, ".fmt"}, 32'(out_fmt), 32'(v.fmt));
    chk({nm, ".reg0"}, 32'(out_reg0), 32'(v.r0));
    chk({nm, ".reg1"}, 32'(out_reg1), 32'(v.r1));
    chk({nm, ".imm"}, 32'(out_imm), 32'(v.imm_s));
    chk({nm, ".illegal"}, 32'(out_illegal), 32'd0);
    chk({nm, ".imm_zext"}, 32'(out_imm_z), 32'(v.imm_z));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vt[0] = '{9'b000101011, 3'd0, 4'd5, 4'd3, 8'h00, 8'h00};  // R3
    vt[1] = '{9'b011101111, 3'd3, 4'd0, 4'd0, 8'hFF, 8'h0F};  // BR negative
    vt[2] = '{9'b011100101, 3'd3, 4'd0, 4'd0, 8'h05, 8'h05};  // BR positive
    vt[3] = '{9'b100001100, 3'd4, 4'd0, 4'd0, 8'h0C, 8'h0C};  // JMP over R1
    vt[4] = '{9'b010110110, 3'd1, 4'd1, 4'd2, 8'h00, 8'h00};  // R2
    vt[5] = '{9'b100101110, 3'd2, 4'd0, 4'd3, 8'h00, 8'h00};  // R1
    vt[6] = '{9'b101011001, 3'd5, 4'd0, 4'd0, 8'h09, 8'h09};  // IMM, zero-ext
    vt[7] = '{9'b100011010, 3'd2, 4'd0, 4'd2, 8'h00, 8'h00};  // R1 next to JMP
    vt[8] = '{9'b001111111, 3'd0, 4'd7, 4'd7, 8'h00, 8'h00};  // R3 all ones
    vt[9] = '{9'b011111000, 3'd3, 4'd0, 4'd0, 8'hF8, 8'h08};  // BR 0111x

    rst_n = 1'b0; in_valid = 1'b0; in_instr = 9'd0; out_ready = 1'b1; trap_clr = 1'b0;
    #3;
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    chk("rst.trap", 32'(trap), 32'd0);
    chk("rst.fmt", 32'(out_fmt), 32'd0);
    chk("rst.opcode", 32'(out_opcode), 32'd0);
    chk("rst.imm", 32'(out_imm), 32'd0);
    chk("rst.regs", 32'({out_reg0, out_reg1}), 32'd0);
    chk("rst.illegal", 32'(out_illegal), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Streaming at one per cycle.
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_instr = vt[i].instr;
      step();
      chk_rec($sformatf("vec%0d", i), vt[i]);
      chk($sformatf("vec%0d.in_ready", i), 32'(in_ready), 32'd1);
    end
    in_valid = 1'b0;
    step();
    chk("drain.out_valid", 32'(out_valid), 32'd0);

    // Backpressure: A, B accepted, C held.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = vt[0].instr;
    step();
    chk_rec("bp.A0", vt[0]);
    chk("bp.ready_one", 32'(in_ready), 32'd1);
    in_instr = vt[1].instr;
    step();
    chk_rec("bp.A1", vt[0]);
    chk("bp.ready_two", 32'(in_ready), 32'd0);
    in_instr = vt[3].instr;
    step();
    chk_rec("bp.A2", vt[0]);
    chk("bp.ready_held", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    step();
    chk_rec("bp.B", vt[1]);
    chk("bp.ready_back", 32'(in_ready), 32'd1);
    step();
    chk_rec("bp.C", vt[3]);
    in_valid = 1'b0;
    step();
    chk("bp.empty", 32'(out_valid), 32'd0);

    // Illegal instruction.
    in_valid = 1'b1;
    in_instr = 9'b110000000;
    step();
    chk("ill.valid", 32'(out_valid), 32'd1);
    chk("ill.illegal", 32'(out_illegal), 32'd1);
    chk("ill.fmt", 32'(out_fmt), 32'd6);
    chk("ill.opcode", 32'(out_opcode), 32'h180);
    chk("ill.imm", 32'(out_imm), 32'd0);
    in_instr = vt[4].instr;
`ifdef DECODE_TRAP_EN
    chk("ill.trap", 32'(trap), 32'd1);
    chk("ill.in_ready", 32'(in_ready), 32'd0);
    step();
    chk("trap.drained", 32'(out_valid), 32'd0);
    chk("trap.blocked", 32'(in_ready), 32'd0);
    chk("trap.held", 32'(trap), 32'd1);
    trap_clr = 1'b1;
    step();
    trap_clr = 1'b0;
    chk("trap.cleared", 32'(trap), 32'd0);
    chk("trap.ready", 32'(in_ready), 32'd1);
    chk("trap.no_out", 32'(out_valid), 32'd0);
    step();
    chk_rec("trap.next", vt[4]);
`else
    chk("ill.trap", 32'(trap), 32'd0);
    chk("ill.in_ready", 32'(in_ready), 32'd1);
    trap_clr = 1'b1;
    step();
    trap_clr = 1'b0;
    chk_rec("ill.next", vt[4]);
    chk("ill.trap_after", 32'(trap), 32'd0);
`endif
    in_valid = 1'b0;
    step();

    // Reset while holding two entries.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = vt[5].instr;
    step();
    in_instr = vt[6].instr;
    step();
    chk("rtwo.in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rtwo.out_valid", 32'(out_valid), 32'd0);
    chk("rtwo.in_ready_rst", 32'(in_ready), 32'd1);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_instr  = vt[8].instr;
    step();
    chk_rec("rtwo.first", vt[8]);
    in_valid = 1'b0;
    step();
    chk("rtwo.empty", 32'(out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
